// File: rtl/gpio_apb_pkg.sv
// Shared types and constants for the GPIO APB master sequencer.
package gpio_apb_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;

  // Sequencer FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETUP  = 2'b01,
    ST_ACCESS = 2'b10,
    ST_DONE   = 2'b11
  } state_t;

  // GPIO slave register offsets
  localparam logic [ADDR_W-1:0] GPIO_DATA_OFS = 4'h0;
  localparam logic [ADDR_W-1:0] GPIO_DIR_OFS  = 4'h4;
  localparam logic [ADDR_W-1:0] GPIO_SET_OFS  = 4'h8;
  localparam logic [ADDR_W-1:0] GPIO_CLR_OFS  = 4'hC;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. Holds the last-owner pointer and, when both
// requesters are active, grants the one that was not served last.
module rr_arb2 (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic [1:0] i_req,
  input  logic       i_upd,
  input  logic       i_owner,
  output logic       o_gnt_idx,
  output logic       o_gnt_vld
);

  logic r_last;

  // Record the requester that just completed; reset value makes req0 win first
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) r_last <= 1'b1;
    else if (i_upd) r_last <= i_owner;
  end

  // Grant selection: single requester wins outright, a tie goes to the other one
  always_comb begin
    o_gnt_vld = |i_req;
    o_gnt_idx = 1'b0;
    if (i_req == 2'b11) o_gnt_idx = ~r_last;
    else if (i_req[1]) o_gnt_idx = 1'b1;
  end

endmodule

// File: rtl/apb_gpio_arbiter.sv
// APB master sequencer sharing one GPIO slave between two requesters.
// Requester handshake: reqN is held high until doneN pulses for one cycle;
// rdataN/errN are valid with doneN and held until the next doneN.
// APB side: SETUP (PSEL) for one cycle, then ACCESS (PSEL+PENABLE) until
// PREADY or timeout; command fields stay stable across both phases.
module apb_gpio_arbiter
  import gpio_apb_pkg::*;
#(
  parameter int TO_CYCLES = 16,
  parameter int TO_W      = 5
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              done0,
  output logic              done1,
  output logic              err0,
  output logic              err1,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  output logic              busy,
  output logic              owner,
  output state_t            o_dbg_state
);

  state_t            r_state;
  state_t            w_next;
  logic              r_owner;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [TO_W-1:0]   r_to_cnt;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;
  logic              r_err0;
  logic              r_err1;
  logic              w_gnt_idx;
  logic              w_gnt_vld;
  logic              w_to_hit;
  logic              w_finish;
  logic              w_sel;

  assign w_to_hit = (r_to_cnt == TO_W'(TO_CYCLES - 1));
  assign w_finish = (r_state == ST_ACCESS) && (PREADY || w_to_hit);

  rr_arb2 u_arb (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .i_req     ({req1, req0}),
    .i_upd     (r_state == ST_DONE),
    .i_owner   (r_owner),
    .o_gnt_idx (w_gnt_idx),
    .o_gnt_vld (w_gnt_vld)
  );

  // FSM state register
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // FSM next state and APB/requester outputs
  always_comb begin
    w_next  = r_state;
    w_sel   = 1'b0;
    PENABLE = 1'b0;
    done0   = 1'b0;
    done1   = 1'b0;
    unique case (r_state)
      ST_IDLE:   if (w_gnt_vld) w_next = ST_SETUP;
      ST_SETUP: begin
        w_sel  = 1'b1;
        w_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        w_sel   = 1'b1;
        PENABLE = 1'b1;
        if (PREADY || w_to_hit) w_next = ST_DONE;
      end
      ST_DONE: begin
        done0  = ~r_owner;
        done1  = r_owner;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign PSEL        = w_sel;
  assign busy        = w_sel;
  assign PWRITE      = w_sel & r_we;
  assign PADDR       = w_sel ? r_addr : '0;
  assign PWDATA      = w_sel ? r_wdata : '0;
  assign owner       = r_owner;
  assign rdata0      = r_rdata0;
  assign rdata1      = r_rdata1;
  assign err0        = r_err0;
  assign err1        = r_err1;
  assign o_dbg_state = r_state;

  // Latch the winner's command on grant; timeout counter restarts for each SETUP
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_owner  <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_to_cnt <= '0;
    end else if (r_state == ST_IDLE && w_gnt_vld) begin
      r_owner  <= w_gnt_idx;
      r_we     <= w_gnt_idx ? we1 : we0;
      r_addr   <= w_gnt_idx ? addr1 : addr0;
      r_wdata  <= w_gnt_idx ? wdata1 : wdata0;
      r_to_cnt <= '0;
    end else if (r_state == ST_ACCESS) begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end

  // Capture result for the owner: PREADY beats a coincident timeout
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_rdata0 <= '0;
      r_rdata1 <= '0;
      r_err0   <= 1'b0;
      r_err1   <= 1'b0;
    end else if (w_finish) begin
      if (!r_owner) begin
        r_err0 <= ~PREADY;
        if (!PREADY)    r_rdata0 <= '0;
        else if (!r_we) r_rdata0 <= PRDATA;
      end else begin
        r_err1 <= ~PREADY;
        if (!PREADY)    r_rdata1 <= '0;
        else if (!r_we) r_rdata1 <= PRDATA;
      end
    end
  end

endmodule

// File: tb/tb_apb_gpio_arbiter.sv
// Self-checking bench for apb_gpio_arbiter: programmable APB slave model,
// scoreboard of {owner, err, rdata} per completed transfer.
module tb_apb_gpio_arbiter;
  import gpio_apb_pkg::*;

  localparam int TO_CYCLES = 16;

  // ---------------- clock / reset ----------------
  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  always #5 PCLK = ~PCLK;

  logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [3:0]  addr0 = 0, addr1 = 0;
  logic [31:0] wdata0 = 0, wdata1 = 0;
  logic [31:0] rdata0, rdata1;
  logic        done0, done1, err0, err1;
  logic        PSEL, PENABLE, PWRITE;
  logic [3:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA = 0;
  logic        PREADY = 0;
  logic        busy, owner;
  state_t      dbg_state;

  apb_gpio_arbiter #(.TO_CYCLES(TO_CYCLES), .TO_W(5)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .rdata0(rdata0), .rdata1(rdata1), .done0(done0), .done1(done1),
    .err0(err0), .err1(err1),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .busy(busy), .owner(owner), .o_dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          failures = 0;
  logic [33:0] exp_q[$];          // {owner, err, rdata}
  logic [31:0] model_rdata[2];
  logic [3:0]  cmd_addr[2];
  logic        cmd_we[2];
  logic [31:0] cmd_wd[2];
  int          ready_at = 0;      // ACCESS cycle that sees PREADY, 0 = never
  logic [31:0] slave_rdata = 0;
  int          acc_cnt = 0;
  logic        prev_psel = 0;
  logic [33:0] mon_e;
  logic        mon_o;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- APB slave model ----------------
  always @(negedge PCLK) begin
    if (PSEL && PENABLE) acc_cnt++;
    else acc_cnt = 0;
    PREADY = (ready_at != 0) && (acc_cnt == ready_at);
    PRDATA = slave_rdata;
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge PCLK) begin
    if (PRESETn) begin
      if (PSEL && !PENABLE) check_eq("setup_after_idle", prev_psel, 1'b0);
      if (PENABLE) check_eq("access_after_setup", {prev_psel, PSEL}, 2'b11);
      if (PSEL && exp_q.size() > 0) begin
        mon_o = exp_q[0][33];
        check_eq("paddr", PADDR, cmd_addr[mon_o]);
        check_eq("pwrite", PWRITE, cmd_we[mon_o]);
        if (cmd_we[mon_o]) check_eq("pwdata", PWDATA, cmd_wd[mon_o]);
      end
      if (done0 || done1) begin
        check_eq("done_onehot", {done1, done0} == 2'b11, 1'b0);
        check_eq("done_psel_low", {PSEL, PENABLE}, 2'b00);
        if (exp_q.size() == 0) begin
          check_eq("spurious_done", 1'b1, 1'b0);
        end else begin
          mon_e = exp_q.pop_front();
          check_eq("done_owner", done1, mon_e[33]);
          check_eq("owner_out", owner, mon_e[33]);
          check_eq("err", done1 ? err1 : err0, mon_e[32]);
          check_eq("rdata", done1 ? rdata1 : rdata0, mon_e[31:0]);
        end
      end
    end
    prev_psel = PSEL;
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    PRESETn = 1'b0;
    req0 = 0; req1 = 0;
    model_rdata[0] = '0; model_rdata[1] = '0;
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
  endtask

  task automatic set_cmd(input int who, input logic we, input logic [3:0] a, input logic [31:0] wd);
    cmd_addr[who] = a; cmd_we[who] = we; cmd_wd[who] = wd;
    if (who == 0) begin we0 = we; addr0 = a; wdata0 = wd; end
    else begin we1 = we; addr1 = a; wdata1 = wd; end
  endtask

  task automatic push_exp(input int who, input int rdy, input logic [31:0] rd);
    logic        e;
    logic [31:0] r;
    e = (rdy == 0) || (rdy > TO_CYCLES);
    if (e) r = '0;
    else if (cmd_we[who]) r = model_rdata[who];
    else r = rd;
    model_rdata[who] = r;
    exp_q.push_back({logic'(who), e, r});
  endtask

  task automatic single_xfer(input string tag, input int who, input logic we, input logic [3:0] a,
                             input logic [31:0] wd, input int rdy, input logic [31:0] rd);
    int n;
    bit seen;
    int exp_cyc;
    set_cmd(who, we, a, wd);
    ready_at = rdy;
    slave_rdata = rd;
    push_exp(who, rdy, rd);
    exp_cyc = ((rdy == 0) || (rdy > TO_CYCLES)) ? 3 + TO_CYCLES : 3 + rdy;
    if (who == 0) req0 = 1'b1; else req1 = 1'b1;
    n = 0; seen = 0;
    while (!seen && n < 60) begin
      @(negedge PCLK);
      n++;
      if (done0 || done1) seen = 1;
    end
    check_eq({tag, "_done_seen"}, seen, 1'b1);
    check_eq({tag, "_cycles"}, n + 1, exp_cyc);
    req0 = 1'b0; req1 = 1'b0;
    @(negedge PCLK);
    check_eq({tag, "_done_one_cycle"}, {done1, done0}, 2'b00);
  endtask

  task automatic wait_dones(input string tag, input int count);
    int n;
    int d;
    n = 0; d = 0;
    while (d < count && n < 200) begin
      @(negedge PCLK);
      n++;
      if (done0 || done1) d++;
    end
    check_eq({tag, "_dones"}, d, count);
    req0 = 1'b0; req1 = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    model_rdata[0] = '0; model_rdata[1] = '0;
    cmd_addr[0] = '0; cmd_addr[1] = '0; cmd_we[0] = 0; cmd_we[1] = 0;
    cmd_wd[0] = '0; cmd_wd[1] = '0;

    // reset state
    @(negedge PCLK);
    check_eq("rst_psel", PSEL, 1'b0);
    check_eq("rst_penable", PENABLE, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_owner", owner, 1'b0);
    check_eq("rst_done", {done1, done0}, 2'b00);
    check_eq("rst_err", {err1, err0}, 2'b00);
    check_eq("rst_rdata0", rdata0, 32'h0);
    check_eq("rst_rdata1", rdata1, 32'h0);
    check_eq("rst_paddr", PADDR, 4'h0);
    check_eq("rst_state", dbg_state, ST_IDLE);
    do_reset();

    // single write and single read, nominal slave
    single_xfer("wr0", 0, 1'b1, GPIO_DIR_OFS, 32'hA5A5_0001, 2, 32'hDEAD_0000);
    single_xfer("rd1", 1, 1'b0, GPIO_DATA_OFS, 32'h0, 2, 32'h0000_00F0);
    check_eq("rd1_hold", rdata1, 32'h0000_00F0);

    // contention from reset pointer: 0,1,0,1
    do_reset();
    set_cmd(0, 1'b1, GPIO_SET_OFS, 32'h1234_5678);
    set_cmd(1, 1'b0, GPIO_CLR_OFS, 32'h0);
    ready_at = 2;
    slave_rdata = 32'h0000_BEEF;
    push_exp(0, 2, slave_rdata); push_exp(1, 2, slave_rdata);
    push_exp(0, 2, slave_rdata); push_exp(1, 2, slave_rdata);
    req0 = 1'b1; req1 = 1'b1;
    wait_dones("contend", 4);
    @(negedge PCLK);

    // timeout, coincident PREADY, minimum-latency slave
    single_xfer("tmo", 0, 1'b0, GPIO_DATA_OFS, 32'h0, 0, 32'h7777_7777);
    check_eq("tmo_psel_low", PSEL, 1'b0);
    single_xfer("tmo_edge", 0, 1'b0, GPIO_DATA_OFS, 32'h0, TO_CYCLES, 32'h0000_5A5A);
    single_xfer("fast1", 1, 1'b1, GPIO_SET_OFS, 32'hCAFE_F00D, 1, 32'h0);
    single_xfer("rd0_rand", 0, 1'b0, GPIO_DIR_OFS, 32'h0, $urandom_range(1, 6), $urandom);

    // reset during ACCESS: last completed owner was req0 before the abort
    single_xfer("pre_rst", 0, 1'b1, GPIO_CLR_OFS, 32'h0000_000F, 2, 32'h0);
    set_cmd(1, 1'b0, GPIO_DATA_OFS, 32'h0);
    ready_at = 0;
    req1 = 1'b1;
    n = 0;
    while (!PENABLE && n < 20) begin @(negedge PCLK); n++; end
    check_eq("abort_reached_access", PENABLE, 1'b1);
    #2 PRESETn = 1'b0;
    #1;
    check_eq("abort_psel", PSEL, 1'b0);
    check_eq("abort_penable", PENABLE, 1'b0);
    check_eq("abort_state", dbg_state, ST_IDLE);
    req1 = 1'b0;
    model_rdata[0] = '0; model_rdata[1] = '0;
    @(negedge PCLK);
    check_eq("abort_no_done", {done1, done0}, 2'b00);
    check_eq("abort_rdata0", rdata0, 32'h0);
    PRESETn = 1'b1;
    @(negedge PCLK);
    check_eq("abort_no_done_after", {done1, done0}, 2'b00);
    set_cmd(0, 1'b0, GPIO_DIR_OFS, 32'h0);
    set_cmd(1, 1'b0, GPIO_DATA_OFS, 32'h0);
    ready_at = 2;
    slave_rdata = 32'h0BAD_C0DE;
    push_exp(0, 2, slave_rdata); push_exp(1, 2, slave_rdata);
    req0 = 1'b1; req1 = 1'b1;
    wait_dones("post_rst", 2);
    repeat (2) @(negedge PCLK);

    check_eq("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // hard time limit
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
